// File: rtl/minifloat_frame_acc.sv
// Expands 7-bit minifloat codes to integers and sums them per frame; result on a valid/ready output.
// Build option: define MINIFLOAT_FRAME_ACC_SAT_EN to clamp the accumulator on overflow instead of wrapping.
module minifloat_frame_acc #(
  parameter int FRAME_LEN = 16,
  parameter int ACC_W     = 15,
  parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_code,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  // state   | meaning
  // ST_ACC  | accepting samples into the running frame
  // ST_DONE | frame result presented, waiting for out_ready
  typedef enum logic {ST_ACC, ST_DONE} state_t;

  localparam int SUM_W = ACC_W + 1;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_ovf_q, out_ovf_d;

  logic [2:0]       code_exp;
  logic [3:0]       code_man;
  logic [10:0]      value;
  logic [SUM_W-1:0] sum_ext;
  logic             carry;
  logic [ACC_W-1:0] acc_add;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;
  logic             close;

  always_comb begin
    code_exp = in_code[6:4];
    code_man = in_code[3:0];
    if (code_exp == 3'd0) begin
      value = {7'd0, code_man};
    end else begin
      value = {6'd0, 1'b1, code_man} << (code_exp - 3'd1);
    end
  end

  always_comb begin
    sum_ext = {1'b0, acc_q} + SUM_W'(value);
    carry   = sum_ext[ACC_W];
`ifdef MINIFLOAT_FRAME_ACC_SAT_EN
    // Once clamped, any further nonzero sample carries again, so the clamp is held.
    acc_add = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    acc_add = sum_ext[ACC_W-1:0];
`endif
    cnt_inc = cnt_q + CNT_W'(1);
  end

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_DONE);
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    accept      = 1'b0;
    close       = 1'b0;

    unique case (state_q)
      ST_ACC: begin
        accept = in_valid;
        close  = (accept && (cnt_inc == CNT_W'(FRAME_LEN))) ||
                 (flush && ((cnt_q != '0) || accept));
        if (accept) begin
          acc_d = acc_add;
          cnt_d = cnt_inc;
          ovf_d = ovf_q | carry;
        end
        if (close) begin
          out_sum_d   = acc_d;
          out_count_d = cnt_d;
          out_ovf_d   = ovf_d;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_minifloat_frame_acc.sv
// Directed bench for minifloat_frame_acc: default instance checked via a frame scoreboard,
// plus a narrow instance (ACC_W=11, FRAME_LEN=4) for overflow handling.
module tb_minifloat_frame_acc;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // default-parameter instance
  logic        in_valid, in_ready, flush, out_valid, out_ready, out_ovf;
  logic [6:0]  in_code;
  logic [14:0] out_sum;
  logic [4:0]  out_count;

  minifloat_frame_acc dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_count(out_count), .out_ovf(out_ovf)
  );

  // narrow instance
  logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready, b_out_ovf;
  logic [6:0]  b_in_code;
  logic [10:0] b_out_sum;
  logic [2:0]  b_out_count;

  minifloat_frame_acc #(.FRAME_LEN(4), .ACC_W(11)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_code(b_in_code),
    .flush(b_flush), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sum(b_out_sum),
    .out_count(b_out_count), .out_ovf(b_out_ovf)
  );

  typedef struct {
    int sum;
    int cnt;
    int ovf;
  } frame_t;

  frame_t sb[$];
  int     checks = 0;
  int     errors = 0;
  int     m_acc = 0, m_cnt = 0, m_ovf = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_val(input logic [6:0] c);
    int e, m;
    e = int'(c[6:4]);
    m = int'(c[3:0]);
    if (e == 0) return m;
    return (16 + m) * (2 ** (e - 1));
  endfunction

  task automatic push_frame();
    frame_t f;
    f.sum = m_acc; f.cnt = m_cnt; f.ovf = m_ovf;
    sb.push_back(f);
    m_acc = 0; m_cnt = 0; m_ovf = 0;
  endtask

  task automatic model_accept(input logic [6:0] code, input logic fl);
    m_cnt++;
    m_acc += exp_val(code);
    if (m_acc >= 32768) begin
      m_ovf = 1;
      m_acc -= 32768;
    end
    if (m_cnt == 16 || fl) push_frame();
  endtask

  task automatic send(input logic [6:0] code, input logic fl);
    int n = 0;
    in_valid = 1'b1; in_code = code; flush = fl;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    check("send_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    model_accept(code, fl);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    if (m_cnt > 0) push_frame();
  endtask

  task automatic check_frame(input string tag);
    int n = 0;
    frame_t f;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_sb_has_entry"}, sb.size() > 0, 1);
    if (sb.size() > 0) begin
      f = sb.pop_front();
      check({tag, "_sum"}, out_sum, f.sum);
      check({tag, "_count"}, out_count, f.cnt);
      check({tag, "_ovf"}, out_ovf, f.ovf);
    end
    check({tag, "_in_ready_low"}, in_ready, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_falls"}, out_valid, 0);
  endtask

  initial begin
    frame_t f;
    rst = 1'b1;
    in_valid = 0; in_code = '0; flush = 0; out_ready = 0;
    b_in_valid = 0; b_in_code = '0; b_flush = 0; b_out_ready = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_count", out_count, 0);
    check("rst_out_ovf", out_ovf, 0);

    // full frame of max codes; result visible one cycle after the 16th accept
    for (int i = 0; i < 16; i++) send(7'h7F, 1'b0);
    check("full_latency", out_valid, 1);
    repeat (2) begin
      @(negedge clk);
      check("full_hold_ready", in_ready, 0);
    end
    check_frame("full");

    // short frame closed by a standalone flush, then an ignored flush at cnt==0
    send(7'h0F, 1'b0);
    send(7'h10, 1'b0);
    send(7'h25, 1'b0);
    do_flush();
    check_frame("flush3");
    do_flush();
    check("empty_flush_sb", sb.size(), 0);
    repeat (3) begin
      @(negedge clk);
      check("empty_flush_no_out", out_valid, 0);
    end

    // backpressure: result held while out_ready is low and in_valid stays high
    for (int i = 0; i < 16; i++) send(7'h01, 1'b0);
    in_valid = 1'b1; in_code = 7'h01;
    f = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", in_ready, 0);
      check("bp_valid", out_valid, 1);
      check("bp_sum", out_sum, f.sum);
      check("bp_count", out_count, f.cnt);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_valid_falls", out_valid, 0);
    check("bp_ready_back", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    model_accept(7'h01, 1'b0);
    do_flush();
    check_frame("bp_next");

    // reset mid-frame discards the partial sum
    for (int i = 0; i < 5; i++) send(7'h10, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", out_valid, 0);
    check("midrst_sum", out_sum, 0);
    check("midrst_count", out_count, 0);
    check("midrst_ready", in_ready, 1);
    rst = 1'b0;
    m_acc = 0; m_cnt = 0; m_ovf = 0;
    for (int i = 0; i < 16; i++) send(7'h01, 1'b0);
    check_frame("after_rst");

    // flush coincident with the closing accept gives one frame only
    for (int i = 0; i < 15; i++) send(7'h05, 1'b0);
    send(7'h05, 1'b1);
    check("flush16_latency", out_valid, 1);
    check_frame("flush16");
    check("flush16_sb_empty", sb.size(), 0);
    repeat (4) begin
      @(negedge clk);
      check("flush16_no_empty", out_valid, 0);
    end

    // narrow instance: overflow with two max codes then flush
    b_in_valid = 1'b1; b_in_code = 7'h7F;
    check("b_ready", b_in_ready, 1);
    repeat (2) @(negedge clk);
    b_in_valid = 1'b0; b_flush = 1'b1;
    @(negedge clk);
    b_flush = 1'b0;
    check("b_ovf_valid", b_out_valid, 1);
`ifdef MINIFLOAT_FRAME_ACC_SAT_EN
    check("b_ovf_sum", b_out_sum, 2047);
`else
    check("b_ovf_sum", b_out_sum, 1920);
`endif
    check("b_ovf_count", b_out_count, 2);
    check("b_ovf_flag", b_out_ovf, 1);
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
    check("b_ovf_valid_falls", b_out_valid, 0);

    // narrow instance: auto-close at FRAME_LEN=4, ovf cleared from previous frame
    b_in_valid = 1'b1; b_in_code = 7'h01;
    repeat (4) @(negedge clk);
    b_in_valid = 1'b0;
    check("b_auto_valid", b_out_valid, 1);
    check("b_auto_sum", b_out_sum, 4);
    check("b_auto_count", b_out_count, 4);
    check("b_auto_ovf", b_out_ovf, 0);
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
